// File: rtl/reg_serializer.sv
// Parallel-to-serial unloader: captures a word on an active-low load and streams it
// one bit per accepted valid/ready handshake, with abort and a one-cycle Done pulse.
module reg_serializer #(
    parameter int DataWidth = 8,
    parameter bit MsbFirst  = 1'b1
) (
    input  logic                 Clk,
    input  logic                 Reset,
    input  logic                 LD,
    input  logic [DataWidth-1:0] DIn,
    input  logic                 Abort,
    input  logic                 SReady,
    output logic                 SOut,
    output logic                 SValid,
    output logic                 Busy,
    output logic                 Done
);

    localparam int CntW = $clog2(DataWidth + 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t               state, state_n;
    logic [DataWidth-1:0] shreg, shreg_n;
    logic [CntW-1:0]      cnt, cnt_n;
    logic                 sout_n, svalid_n, busy_n, done_n;
    logic                 load_ok;

    function automatic logic head(input logic [DataWidth-1:0] v);
        return MsbFirst ? v[DataWidth-1] : v[0];
    endfunction

    function automatic logic [DataWidth-1:0] advance(input logic [DataWidth-1:0] v);
        return MsbFirst ? {v[DataWidth-2:0], 1'b0} : {1'b0, v[DataWidth-1:1]};
    endfunction

    // Abort always beats a load request, including in IDLE.
    assign load_ok = !Abort && !LD;

    always_comb begin
        state_n = state;
        shreg_n = shreg;
        cnt_n   = cnt;
        case (state)
            IDLE: begin
                if (load_ok) begin
                    state_n = SHIFT;
                    shreg_n = DIn;
                    cnt_n   = CntW'(DataWidth);
                end
            end
            SHIFT: begin
                if (Abort) begin
                    state_n = IDLE;
                    cnt_n   = '0;
                end else if (SReady) begin
                    shreg_n = advance(shreg);
                    cnt_n   = (cnt != '0) ? cnt - CntW'(1) : '0;
                    if (cnt <= CntW'(1)) begin
                        state_n = DONE;
                    end
                end
            end
            DONE: begin
                if (Abort) begin
                    state_n = IDLE;
                    cnt_n   = '0;
                end else if (load_ok) begin
                    state_n = SHIFT;
                    shreg_n = DIn;
                    cnt_n   = CntW'(DataWidth);
                end else begin
                    state_n = IDLE;
                end
            end
            default: begin
                state_n = IDLE;
                cnt_n   = '0;
            end
        endcase
    end

    // Outputs are registered from the next state so they line up with the state flops.
    always_comb begin
        sout_n   = 1'b0;
        svalid_n = 1'b0;
        busy_n   = (state_n != IDLE);
        done_n   = (state_n == DONE);
        if (state_n == SHIFT) begin
            sout_n   = head(shreg_n);
            svalid_n = 1'b1;
        end
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state  <= IDLE;
            shreg  <= '0;
            cnt    <= '0;
            SOut   <= 1'b0;
            SValid <= 1'b0;
            Busy   <= 1'b0;
            Done   <= 1'b0;
        end else begin
            state  <= state_n;
            shreg  <= shreg_n;
            cnt    <= cnt_n;
            SOut   <= sout_n;
            SValid <= svalid_n;
            Busy   <= busy_n;
            Done   <= done_n;
        end
    end

endmodule
